pipe_skid_buffer: RTL and testbench



---
 rtl/pipe_skid_buffer.sv | 120 ++++++++++++
 tb/tb_pipe_skid_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// ----------------------------------------------------------------------------
// pipe_skid_buffer
//   Two-entry registered skid buffer between two processor pipeline stages.
//   enq_rdy and all dequeue outputs come from registers only, so there is no
//   combinational path from deq_rdy back to enq_rdy. It sustains one transfer
//   per cycle, keeps strict FIFO order, and supports a synchronous squash
//   that empties the buffer for branch/jump redirects.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      asynchronous active-low reset (0 = asserted)
//   squash     synchronous flush of all buffered entries (highest priority)
//   enq_val    upstream message valid
//   enq_rdy    buffer can accept a message this cycle
//   enq_msg    upstream message, p_nbits wide
//   deq_val    head entry valid
//   deq_rdy    downstream accepts head this cycle
//   deq_msg    head entry data
//   occupancy  number of valid entries (0..2)
// ----------------------------------------------------------------------------
module pipe_skid_buffer #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               squash,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [p_nbits-1:0] main_q,  main_d;
  logic [p_nbits-1:0] skid_q,  skid_d;

  logic enq_fire;
  logic deq_fire;

  // Fire terms are derived from state directly, never from deq_rdy into enq_rdy.
  assign enq_fire = enq_val & (state_q != FULL);
  assign deq_fire = deq_rdy & (state_q != EMPTY);

  // State and data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data steering
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (squash) begin
      // Data registers are left as-is; only the state is flushed.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (enq_fire) begin
            main_d  = enq_msg;
            state_d = ONE;
          end
        end
        ONE: begin
          if (enq_fire && deq_fire) begin
            main_d  = enq_msg;
          end else if (enq_fire) begin
            skid_d  = enq_msg;
            state_d = FULL;
          end else if (deq_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs, registers only
  always_comb begin
    enq_rdy   = (state_q != FULL);
    deq_val   = (state_q != EMPTY);
    deq_msg   = main_q;
    occupancy = state_q;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown({enq_val, deq_rdy, squash}))
        else $error("pipe_skid_buffer: X on enq_val/deq_rdy/squash");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
module tb_pipe_skid_buffer;

  logic        clk;
  logic        reset;
  logic        squash;
  logic        enq_val;
  logic        enq_rdy;
  logic [31:0] enq_msg;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_msg;
  logic [1:0]  occupancy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  pipe_skid_buffer #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .squash    (squash),
    .enq_val   (enq_val),
    .enq_rdy   (enq_rdy),
    .enq_msg   (enq_msg),
    .deq_val   (deq_val),
    .deq_rdy   (deq_rdy),
    .deq_msg   (deq_msg),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one posedge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    squash  = 1'b0;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    enq_msg = '0;
    #1;
    chk("rst0_deq_val", 32'(deq_val), 32'd0);
    chk("rst0_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("rst0_occ",     32'(occupancy), 32'd0);
    chk("rst0_deq_msg", deq_msg, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fill to FULL, then reset asynchronously between edges
    enq_val = 1'b1; enq_msg = 32'h11;
    tick();
    enq_msg = 32'h22;
    tick();
    chk("fill_occ",     32'(occupancy), 32'd2);
    chk("fill_enq_rdy", 32'(enq_rdy), 32'd0);
    enq_val = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_deq_val", 32'(deq_val), 32'd0);
    chk("arst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("arst_occ",     32'(occupancy), 32'd0);
    chk("arst_deq_msg", deq_msg, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single pass
    deq_rdy = 1'b1; enq_val = 1'b1; enq_msg = 32'hA5;
    tick();
    chk("single_val", 32'(deq_val), 32'd1);
    chk("single_msg", deq_msg, 32'hA5);
    enq_val = 1'b0;
    tick();
    chk("single_drain", 32'(deq_val), 32'd0);

    // Backpressure
    deq_rdy = 1'b0; enq_val = 1'b1; enq_msg = 32'h11;
    tick();
    enq_msg = 32'h12;
    tick();
    chk("bp_occ",     32'(occupancy), 32'd2);
    chk("bp_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("bp_head",    deq_msg, 32'h11);
    enq_msg = 32'h13;
    tick();
    chk("bp_stable",     deq_msg, 32'h11);
    chk("bp_stable_occ", 32'(occupancy), 32'd2);
    deq_rdy = 1'b1;
    tick();
    chk("bp_out2",     deq_msg, 32'h12);
    chk("bp_rdy_back", 32'(enq_rdy), 32'd1);
    tick();
    chk("bp_out3",     deq_msg, 32'h13);
    chk("bp_out3_occ", 32'(occupancy), 32'd1);
    enq_val = 1'b0;
    tick();
    chk("bp_empty", 32'(deq_val), 32'd0);

    // Streaming
    enq_val = 1'b1; deq_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enq_msg = 32'(i);
      tick();
      chk("stream_msg", deq_msg, 32'(i));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    enq_val = 1'b0;
    tick();
    chk("stream_drain", 32'(deq_val), 32'd0);

    // Squash in FULL with a colliding enqueue
    deq_rdy = 1'b0; enq_val = 1'b1; enq_msg = 32'h21;
    tick();
    enq_msg = 32'h22;
    tick();
    chk("sq_full_occ", 32'(occupancy), 32'd2);
    squash = 1'b1; enq_msg = 32'h99;
    tick();
    chk("sq_deq_val", 32'(deq_val), 32'd0);
    chk("sq_occ",     32'(occupancy), 32'd0);
    squash = 1'b0; enq_msg = 32'h55;
    tick();
    chk("sq_next_msg", deq_msg, 32'h55);
    chk("sq_next_occ", 32'(occupancy), 32'd1);
    enq_val = 1'b0; deq_rdy = 1'b1;
    tick();
    chk("sq_drain", 32'(deq_val), 32'd0);

    // Simultaneous enq/deq in ONE
    deq_rdy = 1'b0; enq_val = 1'b1; enq_msg = 32'h01;
    tick();
    chk("sim_head", deq_msg, 32'h01);
    deq_rdy = 1'b1; enq_msg = 32'h02;
    tick();
    chk("sim_msg", deq_msg, 32'h02);
    chk("sim_occ", 32'(occupancy), 32'd1);
    enq_val = 1'b0;
    tick();
    chk("sim_drain_val", 32'(deq_val), 32'd0);
    chk("sim_drain_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
